// File: rtl/req_arbiter_rr.sv
// Round-robin merge of MASTER_NUM request channels onto one slave port.
// Read responses are steered back to their master through an in-order ID FIFO.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no grant held; pick the next eligible master from rr_ptr
// BUSY  | grant_id owns the slave port until s_ack or its request drops
`timescale 1ns/1ps
module req_arbiter_rr #(
    parameter int MASTER_NUM = 2,
    parameter int AWIDTH     = 16,
    parameter int DWIDTH     = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic [MASTER_NUM-1:0]        m_req,
    input  logic [MASTER_NUM-1:0]        m_cmd,
    input  logic [MASTER_NUM*AWIDTH-1:0] m_addr,
    input  logic [MASTER_NUM*DWIDTH-1:0] m_wdata,
    output logic [MASTER_NUM-1:0]        m_ack,
    output logic [MASTER_NUM-1:0]        m_resp,
    output logic [DWIDTH-1:0]            m_rdata,
    output logic                         s_req,
    output logic                         s_cmd,
    output logic [AWIDTH-1:0]            s_addr,
    output logic [DWIDTH-1:0]            s_wdata,
    input  logic                         s_ack,
    input  logic                         s_resp,
    input  logic [DWIDTH-1:0]            s_rdata,
    output logic                         rsp_err
);

    localparam int ID_W  = (MASTER_NUM > 2) ? $clog2(MASTER_NUM) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(MASTER_NUM - 1);
    localparam logic [ID_W:0]    NUM_EXT  = (ID_W + 1)'(MASTER_NUM);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]              state;
    logic [ID_W-1:0]         rr_ptr;
    logic [ID_W-1:0]         grant_id;
    logic [ID_W-1:0]         pick_id;
    logic [ID_W:0]           pick_sum;
    logic                    any_elig;
    logic [MASTER_NUM-1:0]   eligible;
    logic [2*MASTER_NUM-1:0] elig_dbl;
    logic [MASTER_NUM-1:0]   elig_rot;

    logic                    sel_req;
    logic                    sel_cmd;
    logic [AWIDTH-1:0]       sel_addr;
    logic [DWIDTH-1:0]       sel_wdata;

    logic                    busy;
    logic                    full;
    logic                    accept;
    logic                    push;
    logic                    pop;

    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        count;
    logic [ID_W-1:0]         id_mem [FIFO_DEPTH];
    logic [ID_W-1:0]         head_id;

    // Reads need a free tracking slot; writes are never held back.
    assign full     = (count == FULL_CNT);
    assign eligible = m_req & (m_cmd | {MASTER_NUM{~full}});

    // Rotate so bit 0 corresponds to rr_ptr, then take the lowest set bit.
    assign elig_dbl = {eligible, eligible};
    assign elig_rot = MASTER_NUM'(elig_dbl >> rr_ptr);

    always_comb begin
        any_elig = 1'b0;
        pick_sum = '0;
        for (int k = 0; k < MASTER_NUM; k++) begin
            if (!any_elig && elig_rot[k]) begin
                any_elig = 1'b1;
                pick_sum = {1'b0, rr_ptr} + (ID_W + 1)'(k);
            end
        end
        pick_id = (pick_sum >= NUM_EXT) ? ID_W'(pick_sum - NUM_EXT) : ID_W'(pick_sum);
    end

    always_comb begin
        sel_req   = 1'b0;
        sel_cmd   = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < MASTER_NUM; i++) begin
            if (grant_id == ID_W'(i)) begin
                sel_req   = m_req[i];
                sel_cmd   = m_cmd[i];
                sel_addr  = m_addr[i*AWIDTH +: AWIDTH];
                sel_wdata = m_wdata[i*DWIDTH +: DWIDTH];
            end
        end
    end

    assign busy    = (state == ST_BUSY);
    assign s_req   = busy & sel_req;
    assign s_cmd   = busy & sel_cmd;
    assign s_addr  = busy ? sel_addr  : '0;
    assign s_wdata = busy ? sel_wdata : '0;

    assign accept  = s_req & s_ack;
    assign push    = accept & ~s_cmd;
    assign pop     = s_resp & (count != '0);
    assign head_id = id_mem[rd_ptr];
    assign m_rdata = s_rdata;

    always_comb begin
        m_ack  = '0;
        m_resp = '0;
        for (int i = 0; i < MASTER_NUM; i++) begin
            m_ack[i]  = accept & (grant_id == ID_W'(i));
            m_resp[i] = pop & (head_id == ID_W'(i));
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_elig) begin
                        grant_id <= pick_id;
                        state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (accept) begin
                        rr_ptr <= (grant_id == LAST_ID) ? '0 : grant_id + ID_W'(1);
                        state  <= ST_IDLE;
                    end else if (!sel_req) begin
                        // Master withdrew without an accept: drop the grant, keep fairness pointer.
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rsp_err <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (s_resp && (count == '0)) rsp_err <= 1'b1;
        end
    end

    // ID storage needs no reset: only entries between rd_ptr and wr_ptr are ever read.
    always_ff @(posedge aclk) begin
        if (push) id_mem[wr_ptr] <= grant_id;
    end

endmodule

// File: tb/tb_req_arbiter_rr.sv
// Self-checking bench for req_arbiter_rr: directed scenarios with a response scoreboard.
`timescale 1ns/1ps
module tb_req_arbiter_rr;

    logic        aclk;
    logic        aresetn;
    logic [1:0]  m_req;
    logic [1:0]  m_cmd;
    logic [31:0] m_addr;
    logic [63:0] m_wdata;
    logic [1:0]  m_ack;
    logic [1:0]  m_resp;
    logic [31:0] m_rdata;
    logic        s_req;
    logic        s_cmd;
    logic [15:0] s_addr;
    logic [31:0] s_wdata;
    logic        s_ack;
    logic        s_resp;
    logic [31:0] s_rdata;
    logic        rsp_err;

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];

    req_arbiter_rr #(
        .MASTER_NUM(2), .AWIDTH(16), .DWIDTH(32), .FIFO_DEPTH(8)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .m_req(m_req), .m_cmd(m_cmd), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_resp(m_resp), .m_rdata(m_rdata),
        .s_req(s_req), .s_cmd(s_cmd), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ack(s_ack), .s_resp(s_resp), .s_rdata(s_rdata),
        .rsp_err(rsp_err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_count(input string tag, input int exp);
        check_val(tag, 64'(dut.count), 64'(exp));
    endtask

    // Entry and exit at a falling edge; inputs set by the caller apply to the current cycle.
    task automatic do_reset();
        aresetn = 1'b0;
        m_req = '0; m_cmd = '0; s_ack = 1'b0; s_resp = 1'b0; s_rdata = '0;
        exp_q.delete();
        #1;
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    task automatic expect_grant(input int id, input bit is_wr, input int budget);
        bit found = 1'b0;
        logic [1:0] oh;
        oh = 2'b01 << id;
        for (int c = 0; c < budget; c++) begin
            #1;
            if (s_req) begin
                found = 1'b1;
                check_val("grant_ack", 64'(m_ack), 64'(oh));
                check_val("grant_cmd", 64'(s_cmd), 64'(is_wr));
                check_val("grant_addr", 64'(s_addr), 64'(m_addr[id*16 +: 16]));
                if (is_wr) check_val("grant_wdata", 64'(s_wdata), 64'(m_wdata[id*32 +: 32]));
                else       exp_q.push_back(id);
            end
            @(negedge aclk);
            if (found) break;
        end
        if (!found) check_val("grant_timeout", 64'(0), 64'(1));
    endtask

    task automatic send_resp(input logic [31:0] d);
        logic [1:0] exp_m;
        int hd;
        s_resp  = 1'b1;
        s_rdata = d;
        #1;
        exp_m = 2'b00;
        if (exp_q.size() > 0) begin
            hd    = exp_q.pop_front();
            exp_m = 2'b01 << hd;
        end
        check_val("resp_route", 64'(m_resp), 64'(exp_m));
        check_val("resp_data", 64'(m_rdata), 64'(d));
        @(negedge aclk);
        s_resp  = 1'b0;
        s_rdata = '0;
    endtask

    initial begin
        bit found;
        int hd;
        aresetn = 1'b0;
        m_req = '0; m_cmd = '0; m_addr = '0; m_wdata = '0;
        s_ack = 1'b0; s_resp = 1'b0; s_rdata = '0;
        #1;
        check_val("rst_sreq", 64'(s_req), 64'(0));
        check_val("rst_mack", 64'(m_ack), 64'(0));
        check_val("rst_saddr", 64'(s_addr), 64'(0));
        check_val("rst_err", 64'(rsp_err), 64'(0));
        check_count("rst_count", 0);
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);

        // Single read from master 0
        m_addr  = {16'h0200, 16'h0010};
        m_wdata = {32'hCAFE0001, 32'hCAFE0000};
        m_req = 2'b01; m_cmd = 2'b00; s_ack = 1'b1;
        #1;
        check_val("single_c0_sreq", 64'(s_req), 64'(0));
        @(negedge aclk);
        #1;
        check_val("single_c1_sreq", 64'(s_req), 64'(1));
        check_val("single_addr", 64'(s_addr), 64'(16'h0010));
        check_val("single_ack", 64'(m_ack), 64'(2'b01));
        exp_q.push_back(0);
        @(negedge aclk);
        m_req = 2'b00;
        check_count("single_count1", 1);
        send_resp(32'hDEADBEEF);
        check_count("single_count0", 0);

        // Round-robin between two continuous readers
        do_reset();
        m_req = 2'b11; m_cmd = 2'b00; s_ack = 1'b1;
        expect_grant(0, 1'b0, 4);
        expect_grant(1, 1'b0, 4);
        expect_grant(0, 1'b0, 4);
        expect_grant(1, 1'b0, 4);
        m_req = 2'b00;
        check_count("rr_count4", 4);
        for (int r = 0; r < 4; r++) send_resp(32'h1000_0000 + 32'(r));
        check_count("rr_count0", 0);

        // Full FIFO blocks reads but not writes
        do_reset();
        m_req = 2'b01; m_cmd = 2'b00; s_ack = 1'b1;
        for (int r = 0; r < 8; r++) expect_grant(0, 1'b0, 4);
        check_count("full_count8", 8);
        m_req = 2'b11; m_cmd = 2'b10;
        expect_grant(1, 1'b1, 4);
        m_req = 2'b01; m_cmd = 2'b00;
        for (int c = 0; c < 3; c++) begin
            #1;
            check_val("full_blocked", 64'(s_req), 64'(0));
            @(negedge aclk);
        end
        send_resp(32'hA5A5_0000);
        #1;
        check_val("full_idle_after_pop", 64'(s_req), 64'(0));
        @(negedge aclk);
        expect_grant(0, 1'b0, 1);
        m_req = 2'b00;
        check_count("full_count_again", 8);

        // Push and pop in the same cycle
        do_reset();
        m_req = 2'b11; m_cmd = 2'b00; s_ack = 1'b1;
        expect_grant(0, 1'b0, 4);
        expect_grant(1, 1'b0, 4);
        expect_grant(0, 1'b0, 4);
        check_count("pp_count3", 3);
        found = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (s_req) begin
                found   = 1'b1;
                s_resp  = 1'b1;
                s_rdata = 32'h1234_5678;
                #1;
                hd = exp_q.pop_front();
                check_val("pp_resp_old_head", 64'(m_resp), 64'(2'b01 << hd));
                check_val("pp_ack", 64'(m_ack), 64'(2'b10));
                check_val("pp_rdata", 64'(m_rdata), 64'(32'h1234_5678));
                exp_q.push_back(1);
            end
            @(negedge aclk);
            s_resp = 1'b0;
            if (found) break;
        end
        if (!found) check_val("pp_timeout", 64'(0), 64'(1));
        m_req = 2'b00;
        check_count("pp_count_same", 3);
        for (int r = 0; r < 3; r++) send_resp(32'h2000_0000 + 32'(r));
        check_count("pp_count0", 0);

        // Spurious response with an empty FIFO
        send_resp(32'h0BAD_0BAD);
        check_val("spur_err", 64'(rsp_err), 64'(1));

        // Build up five outstanding reads, hold a grant, then reset asynchronously
        m_req = 2'b11; m_cmd = 2'b00; s_ack = 1'b1;
        for (int r = 0; r < 5; r++) expect_grant(r % 2, 1'b0, 4);
        check_val("spur_err_sticky", 64'(rsp_err), 64'(1));
        s_ack = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (s_req) begin
                found = 1'b1;
                break;
            end
            @(negedge aclk);
        end
        if (!found) check_val("busy_timeout", 64'(0), 64'(1));
        check_count("mid_count5", 5);
        check_val("mid_no_ack", 64'(m_ack), 64'(0));
        aresetn = 1'b0;
        #1;
        check_val("mid_rst_sreq", 64'(s_req), 64'(0));
        check_val("mid_rst_err", 64'(rsp_err), 64'(0));
        check_count("mid_rst_count", 0);
        @(negedge aclk);
        aresetn = 1'b1;
        exp_q.delete();
        s_ack = 1'b1;
        expect_grant(0, 1'b0, 4);
        m_req = 2'b00;
        send_resp(32'h3000_0000);
        check_val("post_rst_err", 64'(rsp_err), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
